// File: rtl/memrd_pkg.sv
// memrd_stage shared types: FSM states, load funct3 codes,
// hold-register bundle and the misalignment rule.
package memrd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] val;
    logic        load;
    logic        we;
    logic [2:0]  funct3;
  } hold_t;

  // Stores carry their width in inst[14:12]; unknown load codes act as LW.
  function automatic logic misaligned(
    input logic       load,
    input logic [2:0] lf3,
    input logic [2:0] sf3,
    input logic [1:0] lo
  );
    logic half;
    logic word;
    if (load) begin
      half = (lf3 == F3_LH) || (lf3 == F3_LHU);
      word = !half && (lf3 != F3_LB) && (lf3 != F3_LBU);
    end else begin
      half = (sf3[1:0] == 2'b01);
      word = sf3[1];
    end
    return (half & lo[0]) | (word & (lo != 2'b00));
  endfunction

endpackage

// File: rtl/memrd_stage_if.sv
// Single-outstanding request/ack data-memory port.
// master = memrd_stage, slave = memory.
interface memrd_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/memrd_stage_load_fmt.sv
// Load lane select and sign/zero extension.
// Halfword lane comes from lane[1] only.
module load_fmt
  import memrd_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (lane)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  assign h = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    unique case (1'b1)
      (funct3 == F3_LB):  result = {{24{b[7]}}, b};
      (funct3 == F3_LH):  result = {{16{h[15]}}, h};
      (funct3 == F3_LBU): result = {24'b0, b};
      (funct3 == F3_LHU): result = {16'b0, h};
      default:            result = rdata;
    endcase
  end

endmodule

// File: rtl/memrd_stage.sv
// RV32I memory-access stage. Define MEMRD_MISALIGN_TRAP_EN
// to trap misaligned accesses instead of aligning them down.
module memrd_stage
  import memrd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 busy,
  input  logic [31:0]          a_pc,
  input  logic [31:0]          a_inst,
  input  logic                 a_valid,
  input  logic [REG_IDX_W-1:0] a_reg_d,
  input  logic [31:0]          a_reg_d_v,
  input  logic                 a_load_en,
  input  logic [2:0]           a_load_funct3,
  input  logic                 a_store_en,
  input  logic [ADDR_W-1:0]    a_mem_addr,
  input  logic [3:0]           a_store_strb,
  input  logic [31:0]          a_store_data,
  memrd_stage_if.master        dm,
  output logic [31:0]          m_pc,
  output logic [31:0]          m_inst,
  output logic                 m_valid,
  output logic [REG_IDX_W-1:0] m_reg_d,
  output logic [31:0]          m_reg_d_v,
  output logic                 m_exc
);

  state_t state;
  state_t state_nx;

  hold_t                 hold;
  logic [REG_IDX_W-1:0]  h_reg_d;
  logic [ADDR_W-1:0]     h_addr;
  logic [3:0]            h_strb;
  logic [31:0]           h_data;
  logic                  drop;

  logic        mem_op;
  logic        mis;
  logic        start;
  logic [31:0] ld_data;
  logic [31:0] result;

  assign mem_op = a_valid & (a_load_en | a_store_en);

`ifdef MEMRD_MISALIGN_TRAP_EN
  assign mis = mem_op & misaligned(a_load_en, a_load_funct3,
                                   a_inst[14:12], a_mem_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign start = (state == S_IDLE) & !flush & !stall & mem_op & !mis;

  load_fmt u_fmt (
    .rdata  (dm.rdata),
    .lane   (h_addr[1:0]),
    .funct3 (hold.funct3),
    .result (ld_data)
  );

  assign result = hold.load ? ld_data : hold.val;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_WAIT;
      S_WAIT: if (dm.ack) state_nx = stall ? S_HOLD : S_IDLE;
      S_HOLD: if (!stall) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_WAIT) | (state == S_HOLD);
    dm.req = (state == S_WAIT);
  end

  assign dm.we    = hold.we;
  assign dm.addr  = {h_addr[ADDR_W-1:2], 2'b00};
  assign dm.wstrb = h_strb;
  assign dm.wdata = h_data;

  // Hold register; in HOLD, hold.val carries the formatted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      h_reg_d <= '0;
      h_addr  <= '0;
      h_strb  <= '0;
      h_data  <= '0;
      drop    <= 1'b0;
    end else if (start) begin
      hold.pc     <= a_pc;
      hold.inst   <= a_inst;
      hold.val    <= a_reg_d_v;
      hold.load   <= a_load_en;
      hold.we     <= a_store_en & !a_load_en;
      hold.funct3 <= a_load_funct3;
      h_reg_d     <= a_reg_d;
      h_addr      <= a_mem_addr;
      h_strb      <= a_load_en ? 4'b0 : a_store_strb;
      h_data      <= a_store_data;
      drop        <= 1'b0;
    end else if (state == S_WAIT) begin
      if (dm.ack && stall) hold.val <= result;
      drop <= drop | flush;
    end else if (state == S_HOLD) begin
      drop <= drop | flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_pc      <= '0;
      m_inst    <= '0;
      m_valid   <= 1'b0;
      m_reg_d   <= '0;
      m_reg_d_v <= '0;
      m_exc     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (flush) begin
            m_valid <= 1'b0;
            m_exc   <= 1'b0;
          end else if (!stall) begin
            if (start) begin
              m_valid <= 1'b0;
              m_exc   <= 1'b0;
            end else begin
              m_pc      <= a_pc;
              m_inst    <= a_inst;
              m_valid   <= a_valid;
              m_reg_d   <= mis ? '0 : a_reg_d;
              m_reg_d_v <= a_reg_d_v;
              m_exc     <= mis;
            end
          end
        end
        S_WAIT: begin
          if (dm.ack && !stall) begin
            m_pc      <= hold.pc;
            m_inst    <= hold.inst;
            m_valid   <= !(drop | flush);
            m_reg_d   <= h_reg_d;
            m_reg_d_v <= result;
            m_exc     <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            m_pc      <= hold.pc;
            m_inst    <= hold.inst;
            m_valid   <= !(drop | flush);
            m_reg_d   <= h_reg_d;
            m_reg_d_v <= hold.val;
            m_exc     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/memrd_stage.md
# memrd_stage

Parametrised memory-access stage of the RV32I pipeline, between the ALU stage (A_*) and write-back (M_*). It pipelines the instruction context and drives a single-outstanding request/ack data-memory port for loads and stores. Load data is lane-aligned and sign/zero-extended into M_REG_D_V. It honours downstream STALL and pipeline FLUSH, and signals BUSY upstream while a memory access is outstanding.

## Interface
- ADDR_W, 32, data-memory byte-address width (≤32; upper A_*_ADDR bits ignored)
- REG_IDX_W, 5, destination register index width (4 for RV32E)
- CLK  in  1  clock
- RST  in  1  reset; one clock, reset is synchronous and active-high
- STALL  in  1  downstream hold: M_* must not change
- FLUSH  in  1  squash the instruction in this stage
- BUSY  out  1  upstream must hold A_* this cycle
- A_PC, A_INST  in  32 each  instruction context
- A_VALID  in  1  A_* carries a live instruction
- A_REG_D  in  REG_IDX_W  destination register
- A_REG_D_V  in  32  ALU result
- A_LOAD_EN  in  1  load instruction
- A_LOAD_FUNCT3  in  3  load type
- A_STORE_EN  in  1  store instruction
- A_MEM_ADDR  in  ADDR_W  effective byte address
- A_STORE_STRB  in  4  pre-aligned byte strobes
- A_STORE_DATA  in  32  pre-aligned store data
- DM_REQ  out  1  request valid, held until DM_ACK
- DM_WE  out  1  1 = store
- DM_ADDR  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- DM_WSTRB  out  4  byte strobes (0 on loads)
- DM_WDATA  out  32  store data
- DM_ACK  in  1  access complete; DM_RDATA valid for loads
- DM_RDATA  in  32  read word
- M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V  out  32/32/1/REG_IDX_W/32  write-back context
- M_EXC  out  1  misaligned-access exception (see Configuration)

## Operation
- States: IDLE, WAIT, HOLD. An internal hold register captures A_* when an access starts.
- IDLE: if STALL=0, the stage accepts A_*.
  - If there is no memory op (A_VALID=0, or neither EN is set), M_* load A_* directly.
  - If there is a memory op, A_* is captured, the state goes to WAIT, and M_VALID loads 0 (bubble).
- If STALL=1 in IDLE, all registers hold.
- WAIT: DM_REQ=1, and the DM_* signals are driven from the hold register. BUSY=1.
  - On DM_ACK with STALL=0: M_* load from the hold register, with M_REG_D_V = formatted load data (loads) or the held A_REG_D_V (stores). The state goes to IDLE.
  - On DM_ACK with STALL=1: the result is buffered and the state goes to HOLD.
- HOLD: BUSY=1 and DM_REQ=0. When STALL=0, M_* load the buffer and the state goes to IDLE.
- Load format uses addr[1:0] for lane select:
  - LB(000): sign-extended byte.
  - LH(001): sign-extended half at addr[1].
  - LW(010): full word.
  - LBU(100): zero-extended byte.
  - LHU(101): zero-extended half.
  - Other funct3 values are treated as LW.
- A simultaneous load and store (both EN set) is treated as a load.
- FLUSH:
  - In IDLE, M_VALID loads 0 next cycle (even under STALL) and A_* is not accepted.
  - In WAIT, the request cannot be cancelled; a drop flag is set, and on DM_ACK M_VALID=0.
  - In HOLD, the buffered result is marked invalid.

## Timing
- Reset: M_* = 0, M_VALID=0, M_EXC=0, DM_REQ=0, DM_WE=0, DM_ADDR/WSTRB/WDATA=0, BUSY=0, state IDLE.
- Reset during WAIT drops DM_REQ the next cycle. The memory must tolerate an abandoned request.
- Non-memory op: A→M latency is 1 cycle.
- Memory op: latency is 1 + k cycles, where k ≥ 1 is the number of WAIT cycles up to and including the DM_ACK cycle. The minimum is 2.
- BUSY is combinational from state: 1 in WAIT and HOLD.
- DM_* are stable for the whole of WAIT. DM_ACK outside WAIT is ignored.

## Configuration
- MEMRD_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - They issue no DM request and complete in 1 cycle like non-memory ops.
  - They set M_EXC=1 and force M_REG_D=0.
- MEMRD_MISALIGN_TRAP_EN undefined:
  - M_EXC is tied 0.
  - Misaligned addresses are word-aligned down.
  - Halfword lane is selected by addr[1] only.

## Structure
- memrd_pkg holds the state encoding (IDLE/WAIT/HOLD) and the load funct3 constants (LB, LH, LW, LBU, LHU).
- Sub-module load_fmt is purely combinational (DM_RDATA, addr[1:0], funct3 → 32-bit result) and is instantiated once.

## Test plan
- ALU op: PC=0x100, REG_D=3, REG_D_V=0x55 → M_* match one cycle later, DM_REQ never asserted.
- LB from addr 0x203, DM_RDATA=0x80FF_0000 with ACK 3 cycles after request → M_REG_D_V=0xFFFF_FF80, BUSY high for 3 cycles, bubble M_VALID=0 meanwhile.
- SW to 0x40, strobe 0xF, data 0xDEADBEEF, ACK same cycle as REQ → DM_WE=1, DM_ADDR=0x40, completion in 2 cycles.
- LHU at 0x12 with ACK while STALL=1 for 2 cycles, DM_RDATA=0xABCD_1234 → state HOLD, M_REG_D_V=0x0000_ABCD after STALL falls.
- FLUSH during WAIT of LW → request completes on ACK, M_VALID stays 0.
- MEMRD_MISALIGN_TRAP_EN, LW at 0x41 → no DM_REQ, M_EXC=1 after 1 cycle; without the macro → DM_ADDR=0x40, M_EXC=0.
